// File: rtl/txslot_sched.sv
// txslot_sched: master TX slot scheduler choosing SCO/LMP/ACL/POLL per master TX slot; `SCHED_POLL_EN enables POLL scheduling
module txslot_sched #(
  parameter int TPOLL_DEF = 40,
  parameter int CNT_W = 8
) (
  input  logic             clk_6M,
  input  logic             rstz,
  input  logic             conns,
  input  logic             regi_isMaster,
  input  logic             ms_tslot_p,
  input  logic             CLK1,
  input  logic             regi_sco_en,
  input  logic [CNT_W-1:0] regi_Tsco,
  input  logic [CNT_W-1:0] regi_Dsco,
  input  logic [CNT_W-1:0] regi_Tpoll,
  input  logic             lmp_pending,
  input  logic             acl_pending,
  input  logic             acl_flow_stop,
  input  logic [3:0]       regi_acl_pktype,
  input  logic [2:0]       acl_slots,
  output logic             ms_txcmd_p,
  output logic [1:0]       tx_src,
  output logic [3:0]       sched_pktype,
  output logic             tx_reservedslot,
  output logic             txtsco_p,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, DECIDE, ISSUE, HOLD} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] sco_cnt, dsco;
  logic [2:0] slot_rem, len;
  logic clr, mtx, res, sco_en_q, acl_ok, poll_ok, go, acl_sel;
  logic [1:0] src_n;
  logic [3:0] type_n;
  assign clr = rstz | !(conns & regi_isMaster);
  assign mtx = ms_tslot_p & !CLK1;
  assign dsco = regi_Dsco & ~CNT_W'(1);
  assign busy = slot_rem != 3'd0;
  assign ms_txcmd_p = state == ISSUE;
  assign txtsco_p = (state == ISSUE) && (tx_src == 2'd2);
`ifdef SCHED_POLL_EN
  logic [CNT_W-1:0] poll_cnt, tpoll;
  assign tpoll = (regi_Tpoll == '0) ? CNT_W'(TPOLL_DEF) : regi_Tpoll;
  assign poll_ok = poll_cnt == '0;
  // poll counter: saturating count-down per master TX slot, reloaded on any issued command
  always_ff @(posedge clk_6M) begin
    if (clr) poll_cnt <= tpoll;
    else if (state == DECIDE && go) poll_cnt <= tpoll;
    else if (mtx && poll_cnt != '0) poll_cnt <= poll_cnt - CNT_W'(1);
  end
`else
  logic unused_tpoll;
  assign unused_tpoll = ^{regi_Tpoll, CNT_W'(TPOLL_DEF)};
  assign poll_ok = 1'b0;
`endif
  // decision priority and FSM next state
  always_comb begin
    acl_ok = acl_pending & !acl_flow_stop & (!regi_sco_en | (CNT_W'(acl_slots) <= sco_cnt));
    go = res | lmp_pending | acl_ok | poll_ok;
    acl_sel = !res & !lmp_pending & acl_ok;
    src_n = res ? 2'd2 : lmp_pending ? 2'd3 : acl_ok ? 2'd1 : 2'd0;
    type_n = res ? 4'h7 : lmp_pending ? 4'h3 : acl_ok ? regi_acl_pktype : 4'h1;
    state_n = (state == IDLE) ? ((mtx && !busy) ? DECIDE : IDLE) :
              (state == DECIDE) ? (go ? ISSUE : IDLE) :
              (state == ISSUE) ? ((len != 3'd0) ? HOLD : IDLE) :
              (busy ? HOLD : IDLE);
  end
  // state register
  always_ff @(posedge clk_6M) begin
    if (clr) state <= IDLE;
    else state <= state_n;
  end
  // SCO counter, slot occupancy and registered command attributes
  always_ff @(posedge clk_6M) begin
    if (clr) begin
      sco_cnt <= dsco;
      sco_en_q <= 1'b0;
      res <= 1'b0;
      slot_rem <= 3'd0;
      len <= 3'd0;
      tx_src <= 2'd0;
      sched_pktype <= 4'h0;
      tx_reservedslot <= 1'b0;
    end else begin
      sco_en_q <= regi_sco_en;
      if (regi_sco_en && !sco_en_q) sco_cnt <= dsco;
      else if (mtx && regi_sco_en) sco_cnt <= (sco_cnt == '0) ? regi_Tsco - CNT_W'(2) : sco_cnt - CNT_W'(2);
      if (mtx) res <= regi_sco_en && sco_cnt == '0;
      if (state == ISSUE) slot_rem <= len;
      else if (ms_tslot_p && busy) slot_rem <= slot_rem - 3'd1;
      if (ms_tslot_p) tx_reservedslot <= 1'b0;
      else if (state == DECIDE && res) tx_reservedslot <= 1'b1;
      if (state == DECIDE && go) begin
        tx_src <= src_n;
        sched_pktype <= type_n;
        len <= acl_sel ? acl_slots - 3'd1 : 3'd0;
      end
    end
  end
endmodule

// File: tb/tb_txslot_sched.sv
// tb_txslot_sched: randomized scoreboard bench for txslot_sched against a slot-level reference model
module tb_txslot_sched;
  localparam int CNT_W = 8;
  localparam int TPOLL_DEF = 40;
  logic clk_6M = 0, rstz = 1, conns = 1, regi_isMaster = 1, ms_tslot_p = 0, CLK1 = 0, regi_sco_en = 0;
  logic [CNT_W-1:0] regi_Tsco = 6, regi_Dsco = 0, regi_Tpoll = 3;
  logic lmp_pending = 0, acl_pending = 0, acl_flow_stop = 0;
  logic [3:0] regi_acl_pktype = 4'hF;
  logic [2:0] acl_slots = 1;
  logic ms_txcmd_p, tx_reservedslot, txtsco_p, busy;
  logic [1:0] tx_src;
  logic [3:0] sched_pktype;
  typedef struct {int cyc; int src; int typ;} exp_t;
  exp_t q[$];
  int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0;
  int m_sco = 0, m_poll = 3, m_rem = 0;
  bit ph = 0;
  txslot_sched #(.TPOLL_DEF(TPOLL_DEF), .CNT_W(CNT_W)) dut (
    .clk_6M(clk_6M), .rstz(rstz), .conns(conns), .regi_isMaster(regi_isMaster),
    .ms_tslot_p(ms_tslot_p), .CLK1(CLK1), .regi_sco_en(regi_sco_en), .regi_Tsco(regi_Tsco),
    .regi_Dsco(regi_Dsco), .regi_Tpoll(regi_Tpoll), .lmp_pending(lmp_pending),
    .acl_pending(acl_pending), .acl_flow_stop(acl_flow_stop), .regi_acl_pktype(regi_acl_pktype),
    .acl_slots(acl_slots), .ms_txcmd_p(ms_txcmd_p), .tx_src(tx_src), .sched_pktype(sched_pktype),
    .tx_reservedslot(tx_reservedslot), .txtsco_p(txtsco_p), .busy(busy)
  );
  always #5 clk_6M = ~clk_6M;
  always @(posedge clk_6M) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  function automatic int tpoll_eff();
    return (regi_Tpoll == 0) ? TPOLL_DEF : int'(regi_Tpoll);
  endfunction
  task automatic push(input int src, input int typ);
    exp_t e;
    e.cyc = t0 + 2;
    e.src = src;
    e.typ = typ;
    q.push_back(e);
    m_poll = tpoll_eff();
  endtask
  task automatic model_reset();
    m_sco = int'(regi_Dsco) & ~1;
    m_poll = tpoll_eff();
    m_rem = 0;
  endtask
  // one slot boundary: what the air interface should carry in this slot, given current inputs
  task automatic model_slot(input bit c1);
    bit dec, res, acl_ok, poll_ok;
    dec = !c1 && m_rem == 0;
    res = 0;
    if (m_rem > 0) m_rem--;
    if (!c1) begin
      if (regi_sco_en) begin
        res = m_sco == 0;
        m_sco = res ? int'(regi_Tsco) - 2 : m_sco - 2;
      end
      if (m_poll > 0) m_poll--;
    end
    if (dec) begin
      acl_ok = acl_pending && !acl_flow_stop && (!regi_sco_en || int'(acl_slots) <= m_sco);
`ifdef SCHED_POLL_EN
      poll_ok = m_poll == 0;
`else
      poll_ok = 0;
`endif
      if (res) push(2, 7);
      else if (lmp_pending) push(3, 3);
      else if (acl_ok) begin
        push(1, int'(regi_acl_pktype));
        m_rem = int'(acl_slots) - 1;
      end else if (poll_ok) push(0, 1);
    end
  endtask
  task automatic slot();
    @(posedge clk_6M); #1;
    chk("busy", int'(busy), int'(m_rem != 0));
    ms_tslot_p = 1;
    CLK1 = ph;
    t0 = cyc;
    model_slot(ph);
    ph = ~ph;
    @(posedge clk_6M); #1;
    ms_tslot_p = 0;
    repeat (4) @(posedge clk_6M);
    #1;
  endtask
  task automatic slots(input int n);
    for (int i = 0; i < n; i++) slot();
  endtask
  task automatic set_sco(input bit en, input int t, input int d);
    if (en && !regi_sco_en) m_sco = d & ~1;
    regi_sco_en = en;
    regi_Tsco = CNT_W'(t);
    regi_Dsco = CNT_W'(d);
    @(posedge clk_6M); #1;
  endtask
  task automatic check_cleared(input string nm);
    chk({nm, "_q_empty"}, q.size(), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_txcmd"}, int'(ms_txcmd_p), 0);
    chk({nm, "_src"}, int'(tx_src), 0);
    chk({nm, "_pktype"}, int'(sched_pktype), 0);
    chk({nm, "_rsvd"}, int'(tx_reservedslot), 0);
    chk({nm, "_tsco"}, int'(txtsco_p), 0);
  endtask
  task automatic abort_mid_packet(input bit use_rst);
    int k;
    acl_pending = 1;
    acl_slots = 5;
    lmp_pending = 0;
    acl_flow_stop = 0;
    set_sco(0, 6, 0);
    k = 0;
    while (m_rem < 2 && k < 20) begin
      slot();
      k++;
    end
    chk("reached_busy", int'(m_rem >= 2), 1);
    if (use_rst) rstz = 1; else conns = 0;
    @(posedge clk_6M); #1;
    check_cleared(use_rst ? "rst" : "conns");
    rstz = 0;
    conns = 1;
    acl_pending = 0;
    model_reset();
  endtask
  // scoreboard monitor: every command the DUT issues must match the oldest expected one
  always @(negedge clk_6M) begin
    exp_t e;
    if (!rstz && ms_txcmd_p) begin
      if (q.size() == 0) chk("unexpected_cmd", 1, 0);
      else begin
        e = q.pop_front();
        chk("latency", cyc, e.cyc);
        chk("tx_src", int'(tx_src), e.src);
        chk("pktype", int'(sched_pktype), e.typ);
        chk("txtsco_p", int'(txtsco_p), int'(e.src == 2));
        chk("reservedslot", int'(tx_reservedslot), int'(e.src == 2));
      end
    end else if (!rstz && txtsco_p) chk("tsco_without_cmd", 1, 0);
  end
  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (3) @(posedge clk_6M);
    #1;
    check_cleared("reset");
    rstz = 0;
    model_reset();
    slots(14);
    lmp_pending = 1;
    set_sco(1, 6, 2);
    slots(18);
    lmp_pending = 0;
    set_sco(0, 6, 0);
    acl_pending = 1;
    acl_slots = 5;
    regi_acl_pktype = 4'hF;
    slots(20);
    acl_flow_stop = 1;
    slots(16);
    acl_flow_stop = 0;
    slots(6);
    set_sco(1, 6, 4);
    slots(14);
    acl_slots = 3;
    slots(14);
    abort_mid_packet(1);
    slots(10);
    abort_mid_packet(0);
    slots(10);
    for (int i = 0; i < 500; i++) begin
      if (i % 40 == 0) begin
        int t;
        t = 2 * $urandom_range(1, 3);
        regi_Tpoll = CNT_W'($urandom_range(0, 4));
        set_sco(0, t, 0);
        set_sco(bit'($urandom % 2), t, $urandom_range(0, t - 1));
      end
      lmp_pending = ($urandom % 4) == 0;
      acl_pending = $urandom % 2;
      acl_flow_stop = ($urandom % 4) == 0;
      acl_slots = 3'(2 * $urandom_range(0, 2) + 1);
      regi_acl_pktype = 4'($urandom);
      slot();
    end
    repeat (10) @(posedge clk_6M);
    #1;
    chk("final_q_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/txslot_sched.md
Name: txslot_sched

Overview:
- Master-side transmit slot scheduler for the baseband bit-processing datapath.
- At each master TX slot boundary it picks what the packet encoder sends: a SCO reserved packet, a pending LMP message, ACL data, or a POLL.
- It then issues the tx command pulse, packet type and reserved-slot indications.
- It sits between the register/buffer status logic and the header/payload encoders, replacing the tied-off tx_reservedslot/txtsco_p placeholders.

Parameters:
- TPOLL_DEF, 40, poll interval in master TX slots used when regi_Tpoll==0.
- CNT_W, 8, width of the poll and SCO slot counters.

Ports:
- clk_6M  in  1  6 MHz system clock
- rstz  in  1  synchronous reset, active-high
- conns  in  1  connection state active
- regi_isMaster  in  1  scheduler enabled only when 1
- ms_tslot_p  in  1  one-cycle pulse at every 625 us slot boundary
- CLK1  in  1  CLK[1] sampled at ms_tslot_p; 0 = master TX slot
- regi_sco_en  in  1  SCO link enabled
- regi_Tsco  in  CNT_W  SCO interval in slots (2, 4 or 6)
- regi_Dsco  in  CNT_W  SCO offset in slots (even, < Tsco)
- regi_Tpoll  in  CNT_W  poll interval in master TX slots; 0 selects TPOLL_DEF
- lmp_pending  in  1  LMP message queued
- acl_pending  in  1  ACL tx buffer non-empty
- acl_flow_stop  in  1  remote FLOW=0 received
- regi_acl_pktype  in  4  ACL packet type
- acl_slots  in  3  slots occupied by regi_acl_pktype (1, 3 or 5)
- ms_txcmd_p  out  1  one-cycle transmit command
- tx_src  out  2  0=POLL, 1=ACL, 2=SCO, 3=LMP
- sched_pktype  out  4  packet type for the header encoder
- tx_reservedslot  out  1  high for the whole current SCO reserved TX slot
- txtsco_p  out  1  one-cycle pulse coincident with a SCO ms_txcmd_p
- busy  out  1  multi-slot packet in flight

Behaviour:
- Reset (rstz=1 at a clock edge):
  - all outputs 0
  - state IDLE
  - sco_cnt = regi_Dsco
  - poll_cnt = effective Tpoll
  - slot_rem = 0
- Active when conns & regi_isMaster. When inactive:
  - state is forced to IDLE, counters are reloaded as at reset, outputs are 0.
  - a drop of conns mid-packet clears busy on the next clock.
- States:
  - IDLE: waiting for ms_tslot_p.
  - DECIDE: the single cycle after ms_tslot_p with CLK1=0 and slot_rem=0.
  - ISSUE: the cycle after DECIDE; drives ms_txcmd_p and txtsco_p for one cycle.
  - HOLD: while slot_rem>0.
- SCO counter (only when regi_sco_en):
  - On each master TX ms_tslot_p: reserved = (sco_cnt==0).
  - If reserved, sco_cnt loads regi_Tsco-2; otherwise sco_cnt -= 2.
  - Arithmetic is unsigned. Underflow is prevented by the even Dsco/Tsco rule; an odd Dsco is clamped to Dsco&~1.
  - A rising edge of regi_sco_en reloads sco_cnt = regi_Dsco.
- DECIDE priority, evaluated in this order:
  1. SCO reserved → tx_src=2, sched_pktype=4'h7 (HV3), tx_reservedslot=1 until the next ms_tslot_p.
  2. lmp_pending → tx_src=3, type 4'h3 (DM1), one slot.
  3. acl_pending & !acl_flow_stop & (!regi_sco_en | acl_slots ≤ sco_cnt) → tx_src=1, type=regi_acl_pktype.
  4. poll_cnt==0 → tx_src=0, type 4'h1 (POLL).
  5. Otherwise no command is issued and the FSM returns to IDLE.
- The multi-slot fit check in rule 3 uses sco_cnt after its update. An ACL packet that would overlap the next reserved slot is deferred; POLL may still be sent in that slot.
- Latency: ms_txcmd_p is asserted exactly 2 clk_6M cycles after ms_tslot_p.
- tx_src and sched_pktype are registered in DECIDE and held stable until the next DECIDE.
- slot_rem:
  - ISSUE loads slot_rem = occupied slots − 1 (ACL: acl_slots−1; others: 0).
  - Each subsequent ms_tslot_p decrements slot_rem.
  - busy = (slot_rem≠0).
  - A master TX slot that falls while busy is skipped: no DECIDE runs, and sco_cnt and poll_cnt still advance.
- poll_cnt:
  - Decrements on each master TX slot, saturating at 0.
  - Reloads with the effective Tpoll whenever any command (POLL, ACL, LMP or SCO) is issued.
- A slot boundary (ms_tslot_p) that coincides with a regi_* change uses the register values sampled in that same cycle.

Optional Feature:
- Macro SCHED_POLL_EN.
- Defined: poll_cnt exists and priority 4 is active, as described above.
- Undefined:
  - poll_cnt is removed.
  - tx_src=0 is never produced.
  - Slots with nothing pending issue no command.
  - regi_Tpoll and TPOLL_DEF are ignored.

Test Plan:
1. Reset, conns=1, isMaster=1, sco_en=0, nothing pending, Tpoll=3 → POLL ms_txcmd_p on the 3rd master TX slot, 2 cycles after ms_tslot_p; sched_pktype=1; repeats every 3 master TX slots.
2. sco_en=1, Tsco=6, Dsco=2, lmp_pending=1 → reserved slots at master TX slots 2, 5, 8… get tx_src=2, pktype 7, txtsco_p; all other master TX slots get tx_src=3, DM1.
3. acl_pending=1, acl_slots=5, pktype 4'hF, sco_en=0 → one command, busy=1 for 4 slot pulses, next command issued on the first master TX slot after busy clears.
4. Same as 3 with Tsco=6, Dsco=4, i.e. sco_cnt=2 after the update → ACL deferred (POLL if due); on the slot with sco_cnt=4, still deferred with 5-slot packets; with acl_slots=3 at sco_cnt=4, ACL issued.
5. acl_flow_stop=1 with acl_pending=1 → no ACL issued, only POLL at the Tpoll interval; clear flow_stop → ACL issued on the next master TX slot.
6. rstz=1 asserted mid-5-slot packet → next clock: busy=0, all outputs 0; after release, no command until poll_cnt expires (lmp_pending=0).
